// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard scheduler: forward-select encoding
// and the per-stage scoreboard entry.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_EX      = 2'd1,
    FWD_MEM     = 2'd2,
    FWD_WB      = 2'd3
  } fwdSel_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] destination;
    logic       isLoad;
  } sbEntry_t;

  // Register 0 is hardwired, so an entry targeting it never creates a dependency.
  function automatic logic entryMatches(input sbEntry_t e, input logic [4:0] src);
    return e.valid && (e.destination != 5'd0) && (e.destination == src);
  endfunction

endpackage

// File: rtl/operand_hazard_check.sv
// Per-operand dependency check against the EX/MEM/WB scoreboard entries.
// Build option: ID_HAZARD_FORWARDING_EN selects forwarding vs. stall-only resolution.
module operand_hazard_check
  import hazard_pkg::*;
(
  input  logic [4:0] srcReg,
  input  logic       useFlag,
  input  sbEntry_t   exEntry,
  input  sbEntry_t   memEntry,
  input  sbEntry_t   wbEntry,
  output logic       stallReq,
  output fwdSel_t    fwdSel
);

  logic matchEx;
  logic matchMem;
  logic matchWb;
  logic unusedLoadFlags;

  always_comb begin
    matchEx  = useFlag && entryMatches(exEntry, srcReg);
    matchMem = useFlag && entryMatches(memEntry, srcReg);
    matchWb  = useFlag && entryMatches(wbEntry, srcReg);
  end

`ifdef ID_HAZARD_FORWARDING_EN
  // Only a load still in EX lacks a forwardable result; older stages never stall.
  assign unusedLoadFlags = memEntry.isLoad ^ wbEntry.isLoad;

  always_comb begin
    stallReq = matchEx && exEntry.isLoad;
    fwdSel   = FWD_REGFILE;
    if (matchEx) begin
      fwdSel = FWD_EX;
    end else if (matchMem) begin
      fwdSel = FWD_MEM;
    end else if (matchWb) begin
      fwdSel = FWD_WB;
    end
  end
`else
  assign unusedLoadFlags = exEntry.isLoad ^ memEntry.isLoad ^ wbEntry.isLoad;

  always_comb begin
    stallReq = matchEx || matchMem || matchWb;
    fwdSel   = FWD_REGFILE;
  end
`endif

endmodule

// File: rtl/id_hazard_scheduler.sv
// Decode-stage hazard scheduler: EX/MEM/WB destination scoreboard, stall and
// forward-select generation, saturating stall counter. Option: ID_HAZARD_FORWARDING_EN.
module id_hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int unsigned STALL_COUNT_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         id_valid,
  input  logic [4:0]                   id_rs,
  input  logic [4:0]                   id_rt,
  input  logic                         id_usesRs,
  input  logic                         id_usesRt,
  input  logic                         id_writesRegister,
  input  logic [4:0]                   id_destination,
  input  logic                         id_isLoad,
  input  logic                         id_flush,
  output logic                         shouldStall,
  output logic [1:0]                   forwardRs,
  output logic [1:0]                   forwardRt,
  output logic [STALL_COUNT_WIDTH-1:0] stallCount
);

  sbEntry_t exEntry;
  sbEntry_t memEntry;
  sbEntry_t wbEntry;
  logic     rsStall;
  logic     rtStall;
  fwdSel_t  rsSel;
  fwdSel_t  rtSel;
  logic     rsUsed;
  logic     rtUsed;

  assign rsUsed = id_valid & id_usesRs;
  assign rtUsed = id_valid & id_usesRt;

  operand_hazard_check rsCheck (
    .srcReg   (id_rs),
    .useFlag  (rsUsed),
    .exEntry  (exEntry),
    .memEntry (memEntry),
    .wbEntry  (wbEntry),
    .stallReq (rsStall),
    .fwdSel   (rsSel)
  );

  operand_hazard_check rtCheck (
    .srcReg   (id_rt),
    .useFlag  (rtUsed),
    .exEntry  (exEntry),
    .memEntry (memEntry),
    .wbEntry  (wbEntry),
    .stallReq (rtStall),
    .fwdSel   (rtSel)
  );

  // A squashed ID instruction has no operands worth waiting for.
  assign shouldStall = (rsStall | rtStall) & ~id_flush;
  assign forwardRs   = rsSel;
  assign forwardRt   = rtSel;

  always_ff @(posedge clock) begin
    if (reset) begin
      exEntry    <= '0;
      memEntry   <= '0;
      wbEntry    <= '0;
      stallCount <= '0;
    end else begin
      wbEntry              <= memEntry;
      memEntry             <= exEntry;
      exEntry.valid        <= id_valid & id_writesRegister & ~shouldStall & ~id_flush;
      exEntry.destination  <= id_destination;
      exEntry.isLoad       <= id_isLoad;
      if (shouldStall && (stallCount != '1)) begin
        stallCount <= stallCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_hazard_scheduler.sv
// Scoreboard-driven bench for id_hazard_scheduler; expectations follow the
// ID_HAZARD_FORWARDING_EN setting of the build.
`timescale 1ns/1ps
module tb_id_hazard_scheduler;

  localparam int unsigned CW = 4;
`ifdef ID_HAZARD_FORWARDING_EN
  localparam bit FWDON = 1'b1;
`else
  localparam bit FWDON = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [4:0]    id_rs;
  logic [4:0]    id_rt;
  logic          id_usesRs;
  logic          id_usesRt;
  logic          id_writesRegister;
  logic [4:0]    id_destination;
  logic          id_isLoad;
  logic          id_flush;
  logic          shouldStall;
  logic [1:0]    forwardRs;
  logic [1:0]    forwardRt;
  logic [CW-1:0] stallCount;

  id_hazard_scheduler #(.STALL_COUNT_WIDTH(CW)) dut (
    .clock             (clock),
    .reset             (reset),
    .id_valid          (id_valid),
    .id_rs             (id_rs),
    .id_rt             (id_rt),
    .id_usesRs         (id_usesRs),
    .id_usesRt         (id_usesRt),
    .id_writesRegister (id_writesRegister),
    .id_destination    (id_destination),
    .id_isLoad         (id_isLoad),
    .id_flush          (id_flush),
    .shouldStall       (shouldStall),
    .forwardRs         (forwardRs),
    .forwardRt         (forwardRt),
    .stallCount        (stallCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRs;
    logic       usesRt;
    logic       writes;
    logic [4:0] dest;
    logic       isLoad;
    logic       flush;
    logic       expStall;
    logic [1:0] expFRs;
    logic [1:0] expFRt;
  } step_t;

  typedef struct {
    logic          stall;
    logic [1:0]    fRs;
    logic [1:0]    fRt;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          expQ[$];
  int unsigned   checks = 0;
  int unsigned   passed = 0;
  logic [CW-1:0] expCount = '0;

  function automatic step_t mk(input logic rst, valid, input logic [4:0] rs, rt,
                               input logic usesRs, usesRt, writes, input logic [4:0] dest,
                               input logic isLoad, flush, stall, input logic [1:0] fRs, fRt);
    step_t s;
    s.rst = rst; s.valid = valid; s.rs = rs; s.rt = rt; s.usesRs = usesRs; s.usesRt = usesRt;
    s.writes = writes; s.dest = dest; s.isLoad = isLoad; s.flush = flush;
    s.expStall = stall; s.expFRs = fRs; s.expFRt = fRt;
    return s;
  endfunction

  function automatic step_t prod(input logic [4:0] dest, input logic isLoad);
    return mk(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, dest, isLoad, 1'b0, 1'b0, 2'd0, 2'd0);
  endfunction

  function automatic step_t rd(input logic [4:0] rs, rt, input logic usesRs, usesRt,
                               input logic stall, input logic [1:0] fRs, fRt);
    return mk(1'b0, 1'b1, rs, rt, usesRs, usesRt, 1'b0, 5'd0, 1'b0, 1'b0, stall, fRs, fRt);
  endfunction

  function automatic step_t bub();
    return mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
  endfunction

  task automatic drive(input step_t s);
    exp_t e;
    reset = s.rst; id_valid = s.valid; id_rs = s.rs; id_rt = s.rt;
    id_usesRs = s.usesRs; id_usesRt = s.usesRt; id_writesRegister = s.writes;
    id_destination = s.dest; id_isLoad = s.isLoad; id_flush = s.flush;
    e.stall = s.expStall; e.fRs = s.expFRs; e.fRt = s.expFRt; e.cnt = expCount;
    expQ.push_back(e);
  endtask

  task automatic advance(input step_t s);
    @(posedge clock);
    #1;
    if (s.rst) expCount = '0;
    else if (s.expStall && expCount != '1) expCount = expCount + 1'b1;
  endtask

  task automatic test_reset();
    step_t t[$];
    exp_t  e;
    reset = 1'b1; id_valid = 1'b1; id_rs = 5'd5; id_rt = 5'd0; id_usesRs = 1'b1;
    id_usesRt = 1'b0; id_writesRegister = 1'b0; id_destination = 5'd0;
    id_isLoad = 1'b0; id_flush = 1'b0;
    @(posedge clock);
    #1;
    t.push_back(mk(1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    t.push_back(mk(1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    t.push_back(bub());
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clock);
      e = expQ.pop_front();
      checks++; if (shouldStall !== e.stall) $display("FAIL reset[%0d].stall got %0b want %0b", i, shouldStall, e.stall); else passed++;
      checks++; if (stallCount !== e.cnt) $display("FAIL reset[%0d].count got %0d want %0d", i, stallCount, e.cnt); else passed++;
      checks++; if ({forwardRs, forwardRt} !== {e.fRs, e.fRt}) $display("FAIL reset[%0d].fwd got %0d/%0d want %0d/%0d", i, forwardRs, forwardRt, e.fRs, e.fRt); else passed++;
      advance(t[i]);
    end
  endtask

  task automatic test_alu_dep();
    step_t t[$];
    exp_t  e;
    t.push_back(prod(5'd8, 1'b0));
    if (FWDON) t.push_back(rd(5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 2'd1, 2'd1));
    else begin
      repeat (3) t.push_back(rd(5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0));
      t.push_back(rd(5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0));
    end
    repeat (3) t.push_back(bub());
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clock);
      e = expQ.pop_front();
      checks++; if (shouldStall !== e.stall) $display("FAIL alu[%0d].stall got %0b want %0b", i, shouldStall, e.stall); else passed++;
      checks++; if (stallCount !== e.cnt) $display("FAIL alu[%0d].count got %0d want %0d", i, stallCount, e.cnt); else passed++;
      if (!e.stall) begin
        checks++; if ({forwardRs, forwardRt} !== {e.fRs, e.fRt}) $display("FAIL alu[%0d].fwd got %0d/%0d want %0d/%0d", i, forwardRs, forwardRt, e.fRs, e.fRt); else passed++;
      end
      advance(t[i]);
    end
  endtask

  task automatic test_load_use();
    step_t t[$];
    exp_t  e;
    t.push_back(prod(5'd9, 1'b1));
    if (FWDON) begin
      t.push_back(rd(5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0));
      t.push_back(rd(5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2));
    end else begin
      repeat (3) t.push_back(rd(5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0));
      t.push_back(rd(5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
    end
    repeat (3) t.push_back(bub());
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clock);
      e = expQ.pop_front();
      checks++; if (shouldStall !== e.stall) $display("FAIL load[%0d].stall got %0b want %0b", i, shouldStall, e.stall); else passed++;
      checks++; if (stallCount !== e.cnt) $display("FAIL load[%0d].count got %0d want %0d", i, stallCount, e.cnt); else passed++;
      if (!e.stall) begin
        checks++; if ({forwardRs, forwardRt} !== {e.fRs, e.fRt}) $display("FAIL load[%0d].fwd got %0d/%0d want %0d/%0d", i, forwardRs, forwardRt, e.fRs, e.fRt); else passed++;
      end
      advance(t[i]);
    end
  endtask

  task automatic test_reg0();
    step_t t[$];
    exp_t  e;
    t.push_back(prod(5'd0, 1'b0));
    t.push_back(rd(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0));
    t.push_back(prod(5'd0, 1'b1));
    t.push_back(rd(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0));
    repeat (3) t.push_back(bub());
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clock);
      e = expQ.pop_front();
      checks++; if (shouldStall !== e.stall) $display("FAIL reg0[%0d].stall got %0b want %0b", i, shouldStall, e.stall); else passed++;
      checks++; if ({forwardRs, forwardRt} !== {e.fRs, e.fRt}) $display("FAIL reg0[%0d].fwd got %0d/%0d want %0d/%0d", i, forwardRs, forwardRt, e.fRs, e.fRt); else passed++;
      advance(t[i]);
    end
  endtask

  task automatic test_priority();
    step_t t[$];
    exp_t  e;
    t.push_back(prod(5'd4, 1'b0));
    t.push_back(prod(5'd4, 1'b0));
    t.push_back(prod(5'd7, 1'b0));
    if (FWDON) t.push_back(rd(5'd4, 5'd7, 1'b1, 1'b1, 1'b0, 2'd2, 2'd1));
    else begin
      repeat (3) t.push_back(rd(5'd4, 5'd7, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0));
      t.push_back(rd(5'd4, 5'd7, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0));
    end
    repeat (3) t.push_back(bub());
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clock);
      e = expQ.pop_front();
      checks++; if (shouldStall !== e.stall) $display("FAIL prio[%0d].stall got %0b want %0b", i, shouldStall, e.stall); else passed++;
      checks++; if (stallCount !== e.cnt) $display("FAIL prio[%0d].count got %0d want %0d", i, stallCount, e.cnt); else passed++;
      if (!e.stall) begin
        checks++; if ({forwardRs, forwardRt} !== {e.fRs, e.fRt}) $display("FAIL prio[%0d].fwd got %0d/%0d want %0d/%0d", i, forwardRs, forwardRt, e.fRs, e.fRt); else passed++;
      end
      advance(t[i]);
    end
  endtask

  task automatic test_flush();
    step_t t[$];
    exp_t  e;
    t.push_back(prod(5'd12, 1'b1));
    t.push_back(mk(1'b0, 1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 5'd13, 1'b0, 1'b1,
                   1'b0, FWDON ? 2'd1 : 2'd0, 2'd0));
    t.push_back(rd(5'd13, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0));
    repeat (3) t.push_back(bub());
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clock);
      e = expQ.pop_front();
      checks++; if (shouldStall !== e.stall) $display("FAIL flush[%0d].stall got %0b want %0b", i, shouldStall, e.stall); else passed++;
      checks++; if (stallCount !== e.cnt) $display("FAIL flush[%0d].count got %0d want %0d", i, stallCount, e.cnt); else passed++;
      checks++; if ({forwardRs, forwardRt} !== {e.fRs, e.fRt}) $display("FAIL flush[%0d].fwd got %0d/%0d want %0d/%0d", i, forwardRs, forwardRt, e.fRs, e.fRt); else passed++;
      advance(t[i]);
    end
  endtask

  task automatic test_reset_mid_stall();
    step_t t[$];
    exp_t  e;
    t.push_back(prod(5'd20, 1'b1));
    t.push_back(mk(1'b1, 1'b1, 5'd0, 5'd20, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
    t.push_back(rd(5'd0, 5'd20, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
    t.push_back(bub());
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clock);
      e = expQ.pop_front();
      checks++; if (shouldStall !== e.stall) $display("FAIL rststall[%0d].stall got %0b want %0b", i, shouldStall, e.stall); else passed++;
      checks++; if (stallCount !== e.cnt) $display("FAIL rststall[%0d].count got %0d want %0d", i, stallCount, e.cnt); else passed++;
      if (!e.stall) begin
        checks++; if ({forwardRs, forwardRt} !== {e.fRs, e.fRt}) $display("FAIL rststall[%0d].fwd got %0d/%0d want %0d/%0d", i, forwardRs, forwardRt, e.fRs, e.fRt); else passed++;
      end
      advance(t[i]);
    end
  endtask

  task automatic test_saturation();
    step_t t[$];
    exp_t  e;
    for (int k = 0; k < 20; k++) begin
      t.push_back(prod(5'd9, 1'b1));
      if (FWDON) begin
        t.push_back(rd(5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0));
        t.push_back(rd(5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2));
      end else begin
        repeat (3) t.push_back(rd(5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0));
        t.push_back(rd(5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
      end
    end
    t.push_back(bub());
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clock);
      e = expQ.pop_front();
      checks++; if (shouldStall !== e.stall) $display("FAIL sat[%0d].stall got %0b want %0b", i, shouldStall, e.stall); else passed++;
      checks++; if (stallCount !== e.cnt) $display("FAIL sat[%0d].count got %0d want %0d", i, stallCount, e.cnt); else passed++;
      advance(t[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: got no finish, want finish before 200us");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_dep();
    test_load_use();
    test_reg0();
    test_priority();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
